// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter (8N1, LSB first) behind a byte FIFO.
// CPU requests arrive as a go/ack toggle handshake on level-style I/O registers.
//
// state   | meaning
// S_IDLE  | line idle high, waiting for tx_en and a queued byte
// S_START | start bit (low) for CLKS_PER_BIT cycles
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit (high); chains straight into the next frame if one is queued
module io_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_w_data,
    input  logic [31:0] io_w_ctrl,
    output logic [31:0] io_r_status,
    output logic        tx
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [3:0]    DEPTH_C  = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_clk_cnt, w_clk_cnt_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_tx, w_tx_nxt;
    logic          w_pop;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [3:0]    r_count, w_count_nxt;
    logic          r_full, r_empty, r_ack, r_ovf;

    logic w_go, w_clr_ovf, w_tx_en, w_req, w_push, w_drop, w_bit_end, w_busy;
    logic w_unused_bits;

    assign w_go      = io_w_ctrl[0];
    assign w_clr_ovf = io_w_ctrl[1];
    assign w_tx_en   = io_w_ctrl[2];
    assign w_unused_bits = ^{io_w_data[31:8], io_w_ctrl[31:3]};

    // Push legality uses the pre-edge full flag, even if a pop happens this edge.
    assign w_req     = (w_go != r_ack);
    assign w_push    = w_req && !r_full;
    assign w_drop    = w_req && r_full;
    assign w_bit_end = (r_clk_cnt == CNT_LAST);
    assign w_busy    = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_tx_en && !r_empty) begin
                    w_state_nxt   = S_START;
                    w_pop         = 1'b1;
                    w_shift_nxt   = r_mem[r_rptr];
                    w_clk_cnt_nxt = '0;
                    w_tx_nxt      = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_DATA;
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (w_tx_en && !r_empty) begin
                        w_state_nxt = S_START;
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rptr];
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 4'd1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= io_w_data[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_ack     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            if (w_req)
                r_ack <= w_go;
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_clr_ovf)
                r_ovf <= 1'b0;
            if (w_push)
                r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_C);
            r_empty <= (w_count_nxt == 4'd0);
        end
    end

    assign tx          = r_tx;
    assign io_r_status = {20'd0, r_count, 3'd0, r_ovf, r_empty, r_full, w_busy, r_ack};

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Peripheral-side responder for the CPU's memory-mapped I/O register window: it consumes two CPU-written I/O registers and produces one CPU-readable status register. It implements a UART transmitter (8N1, LSB first) with an 8-entry byte FIFO. CPU requests are passed with a toggle handshake, because the write-register window presents levels, not strobes. Top level connects `io_w[0]` to `io_w_data`, `io_w[1]` to `io_w_ctrl`, and `io_r[0]` to `io_r_status`.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 2.
- `FIFO_DEPTH`, default 8: byte FIFO entries; power of two, ≤ 8.
- `clk` in, 1: single clock; all state on posedge.
- `rst` in, 1: asynchronous, active-high reset.
- `io_w_data` in, 32: bits [7:0] are the byte to enqueue; [31:8] ignored.
- `io_w_ctrl` in, 32: bit0 `go` (toggle request), bit1 `clr_ovf` (level), bit2 `tx_en` (level); others ignored.
- `io_r_status` out, 32: bit0 `ack`, bit1 `busy`, bit2 `full`, bit3 `empty`, bit4 `ovf`, [11:8] FIFO count; all other bits 0.
- `tx` out, 1: serial line, idle high.

## Operation
- Inputs change only on negedge `clk` (CPU store path), so they are sampled directly on posedge with no synchronizers.
- **Handshake**
  - A request is pending when `go != ack`.
  - On that edge: `ack <= go`. If `full` is 0, push `io_w_data[7:0]`; otherwise drop the byte and set `ovf`.
  - Exactly one push per toggle. The CPU writes data before toggling `go`.
- **`ovf`**: sticky. Cleared on every edge where `clr_ovf` = 1. A set event on the same edge wins over the clear.
- **FIFO and status**
  - Circular buffer with read and write pointers of `$clog2(FIFO_DEPTH)` bits that wrap modulo depth; count ranges 0..FIFO_DEPTH.
  - `full`/`empty` are registered values derived from the count.
  - Push and pop on the same edge leave the count unchanged. Push legality uses the pre-edge `full`, so a push while full is dropped even if a pop occurs on the same edge.
- **Transmitter FSM**: IDLE, START, DATA, STOP.
  - IDLE→START when `tx_en` and not `empty`. The byte is popped into the shift register on that edge.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then →DATA.
  - DATA: shift out bits 0..7, each for CLKS_PER_BIT cycles. A 3-bit index wraps 7→0, then →STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, go →START with a pop if `tx_en` and not `empty`, otherwise →IDLE. Back-to-back frames have no gap.
  - Clearing `tx_en` mid-frame does not abort the frame; it only blocks the next start.
- `busy` = (state != IDLE).
- Bit counter is `$clog2(CLKS_PER_BIT)` bits, counts 0..CLKS_PER_BIT-1, and resets to 0 at each bit boundary.
- `tx` is registered (no glitches).

## Timing
- Reset values:
  - `tx`=1, state IDLE, pointers/count 0, `ack`=0, `ovf`=0.
  - `io_r_status` = 0x0000_0008.
  - Reset is asynchronous, so an in-flight frame is aborted and `tx` goes high immediately.
- `go` toggles on negedge → at the next posedge `ack`/count update → visible on `io_r_status` after that edge, giving the CPU 1-cycle read latency.
- Enqueue to empty FIFO with idle FSM and `tx_en`=1:
  - Push at edge N, START entered at edge N+1, `tx` falls after edge N+1.
  - Frame occupies exactly 10×CLKS_PER_BIT cycles; `busy` drops the edge after the stop bit ends.
- Status reflects post-edge register state; no combinational path from inputs to outputs.

## Test plan
- Reset with CLKS_PER_BIT=4 → `io_r_status`=0x0000_0008, `tx`=1; assert `rst` mid-DATA → `tx`=1 within the same cycle, status 0x0000_0008.
- `tx_en`=1, data 0x55, toggle `go` → `ack`=1 one cycle later; `tx` shows 0 (4 cycles), then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 (4 cycles); `busy` high for 40 cycles.
- `tx_en`=0, nine toggles with data 0x01..0x09 → count=8, `full`=1, `ovf`=1, `ack`==`go` after each; byte 0x09 is never transmitted.
- Pulse `clr_ovf`, set `tx_en`=1 → `ovf`=0; bytes 0x01..0x08 are sent back-to-back in 320 cycles with no idle cycle, then `empty`=1 and `busy`=0.
- FIFO full, toggle `go` on the same edge as a START pop → byte dropped, `ovf`=1, count goes 8→7.
- Clear `tx_en` during frame 1 of 3 queued bytes → frame 1 completes, FSM returns to IDLE, count=2; set `tx_en` → remaining two frames transmitted.
